board_row_renderer: RTL



---
 rtl/board_row_renderer.sv | 113 +++++++++++
 1 files changed

// File: rtl/board_row_renderer.sv
// Pixel stage behind the Life engine: prefetches each 64-cell row into a shadow
// line buffer during horizontal blanking, swaps it in at the row boundary, and renders cell icons.
module board_row_renderer #(
    parameter int X0    = 64,
    parameter int Y0    = 112,
    parameter int LOG_W = 6,
    parameter int LOG_H = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   display_on,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    output logic                   rd_req,
    output logic [LOG_H+LOG_W-1:0] rd_addr,
    input  logic                   rd_gnt,
    input  logic                   rd_data,
    output logic [7:0]             vga_out,
    output logic                   underrun
);
    localparam int W = 1 << LOG_W;
    localparam logic [9:0] XL = 10'(X0);
    localparam logic [9:0] XR = 10'(640 - X0);
    localparam logic [9:0] YT = 10'(Y0);
    localparam logic [9:0] YB = 10'(480 - Y0);
    localparam logic [9:0] ROWS_PX = 10'(8 << LOG_H);
    // 8x8 icon; rows and columns are symmetric so bit order is immaterial
    localparam logic [63:0] ICON = {8'h00, 8'h3C, {4{8'h7E}}, 8'h3C, 8'h00};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

    state_t             state, state_nx;
    logic [LOG_H-1:0]   row;
    logic [LOG_W-1:0]   col, col_q;
    logic               issue, issue_q;
    logic [W-1:0]       shadow, active;

    // Offset of the scanline after this one from the top of the board
    logic [9:0]         vnext;
    logic               trig_line, trigger, swap;
    logic [LOG_H-1:0]   target_row;

    assign vnext      = vpos + 10'd1 - YT;
    assign trig_line  = (vpos + 10'd1 >= YT) && (vnext[2:0] == 3'd0) && (vnext < ROWS_PX);
    assign target_row = vnext[LOG_H+2:3];
    assign trigger    = trig_line && (hpos == 10'd640);
    assign swap       = trig_line && (hpos == 10'd799);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE:  if (trigger) state_nx = FETCH;
            FETCH: begin
                issue = rd_gnt;
                if (rd_gnt && col == '1) state_nx = DRAIN;
            end
            DRAIN: state_nx = READY;
            READY: state_nx = READY;
            default: state_nx = IDLE;
        endcase
        if (swap) state_nx = IDLE;
    end

    assign rd_req  = (state == FETCH);
    assign rd_addr = {row, col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            col_q    <= '0;
            issue_q  <= 1'b0;
            shadow   <= '0;
            active   <= '0;
            underrun <= 1'b0;
        end else begin
            state   <= state_nx;
            issue_q <= issue & ~swap;
            if (issue) col_q <= col;
            if (state == IDLE && trigger) begin
                row <= target_row;
                col <= '0;
            end else if (issue && col != '1) begin
                col <= col + 1'b1;
            end
            // Data returns one cycle after issue, regardless of the current grant
            if (issue_q) shadow[col_q] <= rd_data;
            if (swap) begin
                if (state == READY) active <= shadow;
                else if (state == FETCH || state == DRAIN) underrun <= 1'b1;
            end
        end
    end

    logic             in_frame, lit, hi;
    logic [LOG_W-1:0] cell_idx;

    always_comb begin
        in_frame = (hpos >= XL) && (hpos < XR) && (vpos >= YT) && (vpos < YB);
        cell_idx = LOG_W'((hpos - XL) >> 3);
        lit      = display_on & in_frame;
        hi       = lit & active[cell_idx] & ICON[{vpos[2:0], hpos[2:0]}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vga_out <= '0;
        else        vga_out <= {hsync_in, 1'b1, lit, lit, vsync_in, 1'b0, hi, hi};
    end
endmodule
